// File: rtl/sseg_scan_ctrl.sv
// Scan and update controller for a 4-digit seven-segment display.
// Steps digit_sel through 0..3 with a fixed slot length. Each slot opens with
// an anti-ghosting blank window and is then PWM-gated by a per-slot brightness.
// Display updates arrive on a valid/ready port and sit in a single-entry
// buffer. They reach the decoder only at frame boundaries, so no frame ever
// shows a mix of old and new digits.
module sseg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000,
    parameter int PWM_BITS    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic                upd_valid,
    input  logic [15:0]         upd_data,
    input  logic                upd_hex_dec,
    input  logic                upd_sign,
    output logic                upd_ready,
    output logic [15:0]         data,
    output logic                hex_dec,
    output logic                sign,
    output logic [1:0]          digit_sel,
    output logic                blank,
    output logic                frame_start
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYC);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          dsel_q, dsel_d;
    logic [PWM_BITS-1:0] bright_q, bright_d;
    logic                pend_full_q, pend_full_d;
    logic [15:0]         pend_data_q, pend_data_d;
    logic                pend_hex_q, pend_hex_d;
    logic                pend_sign_q, pend_sign_d;
    logic [15:0]         data_q, data_d;
    logic                hex_q, hex_d;
    logic                sign_q, sign_d;

    logic                slot_start;   // next cycle is cnt = 0 in SCAN
    logic                frame_load;   // next cycle is a frame_start cycle
    logic                accept;
    logic                consume;
    logic [PWM_BITS-1:0] phase;

    // State, scan counters, brightness latch, pending buffer and displayed word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dsel_q      <= '0;
            bright_q    <= '0;
            pend_full_q <= 1'b0;
            pend_data_q <= '0;
            pend_hex_q  <= 1'b0;
            pend_sign_q <= 1'b0;
            data_q      <= '0;
            hex_q       <= 1'b0;
            sign_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dsel_q      <= dsel_d;
            bright_q    <= bright_d;
            pend_full_q <= pend_full_d;
            pend_data_q <= pend_data_d;
            pend_hex_q  <= pend_hex_d;
            pend_sign_q <= pend_sign_d;
            data_q      <= data_d;
            hex_q       <= hex_d;
            sign_q      <= sign_d;
        end
    end

    // Next-state: scan sequencing, frame boundary detection and buffer moves
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dsel_d     = dsel_q;
        slot_start = 1'b0;
        frame_load = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                dsel_d = '0;
                if (en) begin
                    // Entering SCAN always begins a fresh frame at digit 0
                    state_d    = SCAN;
                    slot_start = 1'b1;
                    frame_load = 1'b1;
                end
            end
            SCAN: begin
                if (!en) begin
                    // Abandon the slot immediately; nothing is completed
                    state_d = IDLE;
                    cnt_d   = '0;
                    dsel_d  = '0;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d      = '0;
                    dsel_d     = dsel_q + 2'd1;
                    slot_start = 1'b1;
                    frame_load = (dsel_q == 2'd3);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Ready is low while full, so a consume and an accept never coincide
        accept  = upd_valid && !pend_full_q;
        consume = frame_load && pend_full_q;

        pend_full_d = pend_full_q;
        pend_data_d = pend_data_q;
        pend_hex_d  = pend_hex_q;
        pend_sign_d = pend_sign_q;
        if (consume) begin
            pend_full_d = 1'b0;
        end else if (accept) begin
            pend_full_d = 1'b1;
            pend_data_d = upd_data;
            pend_hex_d  = upd_hex_dec;
            pend_sign_d = upd_sign;
        end

        data_d = consume ? pend_data_q : data_q;
        hex_d  = consume ? pend_hex_q  : hex_q;
        sign_d = consume ? pend_sign_q : sign_q;

        // Brightness only changes at slot granularity
        bright_d = slot_start ? brightness : bright_q;
    end

    // Blank window then PWM gating; phase restarts at the end of the window
    always_comb begin
        phase = PWM_BITS'(cnt_q - BLANK_C);
        blank = 1'b1;
        if (state_q == SCAN && cnt_q >= BLANK_C) begin
            if (bright_q == '1 || phase < bright_q)
                blank = 1'b0;
        end
    end

    assign frame_start = (state_q == SCAN) && (cnt_q == '0) && (dsel_q == 2'd0);
    assign upd_ready   = !pend_full_q;
    assign digit_sel   = dsel_q;
    assign data        = data_q;
    assign hex_dec     = hex_q;
    assign sign        = sign_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with REFRESH_DIV=8, BLANK_CYC=2, PWM_BITS=2.
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_sseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  brightness;
    logic        upd_valid;
    logic [15:0] upd_data;
    logic        upd_hex_dec;
    logic        upd_sign;
    logic        upd_ready;
    logic [15:0] data;
    logic        hex_dec;
    logic        sign;
    logic [1:0]  digit_sel;
    logic        blank;
    logic        frame_start;

    sseg_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYC(2), .PWM_BITS(2)) dut (
        .clk(clk), .rst(rst), .en(en), .brightness(brightness),
        .upd_valid(upd_valid), .upd_data(upd_data), .upd_hex_dec(upd_hex_dec),
        .upd_sign(upd_sign), .upd_ready(upd_ready), .data(data),
        .hex_dec(hex_dec), .sign(sign), .digit_sel(digit_sel),
        .blank(blank), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] br;
        logic [7:0] mask;   // bit c = expected blank at cnt c
    } vec_t;

    vec_t vecs[5];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   t;                // expected cycle index within the current scan run

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at t=%0d: got %0h, want %0h", name, t, act, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
        t++;
    endtask

    initial begin
        vecs[0] = '{br: 2'd3, mask: 8'b0000_0011};
        vecs[1] = '{br: 2'd1, mask: 8'b1011_1011};
        vecs[2] = '{br: 2'd0, mask: 8'b1111_1111};
        vecs[3] = '{br: 2'd2, mask: 8'b0011_0011};
        vecs[4] = '{br: 2'd3, mask: 8'b0000_0011};

        rst = 1'b1; en = 1'b0; brightness = 2'd0;
        upd_valid = 1'b1; upd_data = 16'hDEAD; upd_hex_dec = 1'b1; upd_sign = 1'b1;
        t = 0;

        // Reset values, with a valid word offered that must be ignored
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", upd_ready, 1);
        chk("rst_data", data, 0);
        chk("rst_hex", hex_dec, 0);
        chk("rst_sign", sign, 0);
        chk("rst_dsel", digit_sel, 0);
        chk("rst_blank", blank, 1);
        chk("rst_fs", frame_start, 0);
        rst = 1'b0; upd_valid = 1'b0;
        @(negedge clk);
        chk("idle_blank", blank, 1);
        chk("idle_ready", upd_ready, 1);

        // Scan at full brightness for 40 cycles
        en = 1'b1; brightness = 2'd3;
        t = -1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            chk("scan_dsel", digit_sel, (i / 8) % 4);
            chk("scan_fs", frame_start, (i % 32) == 0);
            chk("scan_blank", blank, (i % 8) < 2);
        end

        // Brightness table; a mid-slot change must not affect the slot
        for (int v = 0; v < 5; v++) begin
            brightness = vecs[v].br;
            for (int c = 0; c < 8; c++) begin
                cyc();
                chk("pwm_blank", blank, vecs[v].mask[c]);
                if (c == 3) brightness = 2'(vecs[v].br + 2'd1);
            end
        end
        brightness = 2'd3;   // t=79: digit 1, cnt 7

        // Single update sent during digit 2
        cyc();               // t=80
        upd_valid = 1'b1; upd_data = 16'h1234; upd_hex_dec = 1'b1; upd_sign = 1'b1;
        cyc();               // t=81
        upd_valid = 1'b0; upd_data = 16'hFFFF;
        for (int i = 81; i < 96; i++) begin
            if (i > 81) cyc();
            chk("upd_ready_low", upd_ready, 0);
            chk("upd_data_old", data, 0);
        end
        cyc();               // t=96 frame start
        chk("upd_fs", frame_start, 1);
        chk("upd_data_new", data, 16'h1234);
        chk("upd_hex_new", hex_dec, 1);
        chk("upd_sign_new", sign, 1);
        chk("upd_ready_fs", upd_ready, 1);
        cyc();               // t=97
        chk("upd_ready_after", upd_ready, 1);

        // Back-to-back held valid: AAAA then BBBB
        upd_valid = 1'b1; upd_data = 16'hAAAA; upd_hex_dec = 1'b0; upd_sign = 1'b0;
        cyc();               // t=98
        chk("aa_accepted", upd_ready, 0);
        upd_data = 16'hBBBB; upd_hex_dec = 1'b1;
        while (t < 127) begin
            cyc();
            chk("aa_hold_ready", upd_ready, 0);
            chk("aa_hold_data", data, 16'h1234);
        end
        cyc();               // t=128
        chk("aa_fs", frame_start, 1);
        chk("aa_data", data, 16'hAAAA);
        chk("aa_hex", hex_dec, 0);
        chk("aa_ready", upd_ready, 1);
        cyc();               // t=129
        chk("bb_accepted", upd_ready, 0);
        upd_valid = 1'b0;
        while (t < 159) cyc();
        chk("bb_not_yet", data, 16'hAAAA);
        cyc();               // t=160
        chk("bb_fs", frame_start, 1);
        chk("bb_data", data, 16'hBBBB);
        chk("bb_hex", hex_dec, 1);

        // Queue 5678, then drop en at digit 1, cnt 4
        upd_valid = 1'b1; upd_data = 16'h5678; upd_hex_dec = 1'b0; upd_sign = 1'b1;
        cyc();               // t=161
        upd_valid = 1'b0;
        while (t < 172) cyc();
        chk("drop_dsel_before", digit_sel, 1);
        chk("drop_blank_before", blank, 0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("idle_blank", blank, 1);
            chk("idle_dsel", digit_sel, 0);
            chk("idle_fs", frame_start, 0);
            chk("idle_keep_data", data, 16'hBBBB);
            chk("idle_pending", upd_ready, 0);
        end
        en = 1'b1;
        t = -1;
        cyc();               // t=0 of the new scan run
        chk("reen_fs", frame_start, 1);
        chk("reen_data", data, 16'h5678);
        chk("reen_sign", sign, 1);
        chk("reen_ready", upd_ready, 1);
        cyc(); cyc();        // t=2
        chk("reen_lit", blank, 0);

        // Reset mid-slot with the buffer full
        upd_valid = 1'b1; upd_data = 16'h9999; upd_hex_dec = 1'b1; upd_sign = 1'b0;
        cyc();               // t=3
        upd_valid = 1'b0;
        chk("pre_rst_full", upd_ready, 0);
        while (t < 12) cyc();
        chk("pre_rst_dsel", digit_sel, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_data", data, 0);
        chk("arst_sign", sign, 0);
        chk("arst_dsel", digit_sel, 0);
        chk("arst_blank", blank, 1);
        chk("arst_fs", frame_start, 0);
        chk("arst_ready", upd_ready, 1);
        cyc(); cyc();
        rst = 1'b0;
        cyc();               // back in SCAN, buffer must have been emptied
        chk("post_rst_fs", frame_start, 1);
        chk("post_rst_data", data, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
Scan and update controller for the 4-digit seven-segment display driver.
- Sequences digit_sel through digits 0..3 at a programmable slot rate.
- Adds an anti-ghosting blank window and PWM brightness gating per slot.
- Buffers display updates from a valid/ready producer and applies them only at frame boundaries, so a frame never shows mixed old and new data.
- Sits between the application logic and the display decoder, replacing a free-running counter's MSBs as the digit select source.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot; legal range >= 2.
- BLANK_CYC, 1000: cycles at the start of each slot with display forced blank; must be < REFRESH_DIV.
- PWM_BITS, 4: width of the brightness input and of the PWM phase.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous active-high reset
- en  input  1  scan enable
- brightness  input  PWM_BITS  duty select, 0 = dark, all-ones = full on
- upd_valid  input  1  producer has a new display word
- upd_data  input  16  four hex/BCD nibbles, digit 0 = bits [3:0]
- upd_hex_dec  input  1  format flag accompanying upd_data
- upd_sign  input  1  sign flag accompanying upd_data
- upd_ready  output  1  pending buffer empty; transfer occurs when upd_valid & upd_ready
- data  output  16  displayed word, to decoder
- hex_dec  output  1  displayed format flag
- sign  output  1  displayed sign flag
- digit_sel  output  2  active digit index
- blank  output  1  1 = all anodes off
- frame_start  output  1  one-cycle pulse, first cycle of each digit-0 slot

Behaviour:
Reset values (asynchronous):
- State = IDLE; slot counter cnt = 0; digit_sel = 0.
- data = 0; hex_dec = 0; sign = 0.
- blank = 1; frame_start = 0; pending buffer empty; bright_q = 0.
- Handshake transfers are ignored while rst = 1.

States:
- IDLE:
  - blank = 1; cnt and digit_sel held at 0.
  - en = 1 -> SCAN.
- SCAN:
  - cnt increments each cycle 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, digit_sel advances 0->1->2->3->0.
  - en = 0 sampled -> IDLE at the next edge, with cnt = 0 and digit_sel = 0. This applies mid-slot too, with no completion of the slot.
- Entry into SCAN, and every wrap into digit 0, is a frame boundary.

Frame boundary:
- frame_start = 1 in the first SCAN cycle with digit_sel = 0 and cnt = 0; 0 otherwise.
- At the edge entering that cycle, if the pending buffer is full, data, hex_dec and sign load from it and the buffer empties. The new word is visible in the frame_start cycle.
- bright_q samples brightness at every slot start (cnt = 0). Brightness changes take effect only at slot granularity.

Handshake and buffering:
- upd_ready = NOT pending_full. It is combinational from a register and does not depend on upd_valid.
- A transfer fills the pending buffer. upd_valid may be held indefinitely without side effects.
- A second word cannot be accepted until the current pending word is consumed, so at most one word is pending.
- Consume and accept in the same cycle cannot occur, because ready is low whenever pending is full. Ready rises the cycle after the consuming edge.
- Handshake operates in IDLE and SCAN alike. A pending word is retained across en toggles and applied at the next frame boundary.

Blank logic (combinational from registered state):
- IDLE: blank = 1.
- SCAN with cnt < BLANK_CYC: blank = 1.
- Otherwise, phase = (cnt - BLANK_CYC) mod 2^PWM_BITS.
  - Lit (blank = 0) iff bright_q is all-ones, or phase < bright_q.
  - bright_q = 0 -> always blank.

Test Plan:
Use REFRESH_DIV=8, BLANK_CYC=2, PWM_BITS=2.
- Reset, then en=1, brightness=3 -> digit_sel sequence 0,1,2,3,0 in 8-cycle slots. frame_start pulses every 32 cycles. blank=1 at cnt 0-1 and 0 at cnt 2-7 in every slot.
- brightness=1 -> lit only at cnt 2 and 6 of each slot. brightness=0 -> blank=1 throughout. Change brightness mid-slot -> no effect until the next cnt=0.
- During digit 2, send upd_data=16'h1234 with valid -> accepted in one cycle, upd_ready=0 until frame start. data=0 through digit 3; data=16'h1234 in the frame_start cycle; upd_ready=1 the following cycle.
- Hold upd_valid with 16'hAAAA then 16'hBBBB back-to-back -> only 16'hAAAA accepted before the boundary. 16'hBBBB is accepted the cycle after consumption and displayed at the next frame.
- Drop en at digit 1, cnt 4 -> next cycle blank=1, digit_sel=0. Re-assert en -> frame_start in the first SCAN cycle, and the pending word is applied there.
- Assert rst mid-slot with the buffer full -> all outputs return to reset values asynchronously, the buffer empties, and upd_ready=1.
